// File: rtl/tgl_hs_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tgl_hs_responder_if : toggle request/ack link plus valid/ready port    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface tgl_hs_responder_if #(
  parameter int DW = 8
);
  logic          req_t;
  logic [DW-1:0] din;
  logic          ack_t;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output req_t, din, out_ready,
    input  ack_t, out_valid, out_data
  );

  modport slave (
    input  req_t, din, out_ready,
    output ack_t, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/tgl_hs_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tgl_hs_responder : two-phase request responder with valid/ready output |
// | Optional one-entry skid buffer: define TGL_HS_RESP_SKID_EN.  Rev 1.0   |
// +----------------------------------------------------------------------+
module tgl_hs_responder #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  tgl_hs_responder_if.slave hs,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err,
  input  logic             err_clr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_last_q;
  logic                   req_s;
  logic                   evt;
  logic                   hold_refill;

  logic [0:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign evt   = req_s ^ req_last_q;

`ifdef TGL_HS_RESP_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  // A consumed HOLD entry is immediately replaced by a skid entry or a same-cycle event.
  assign hold_refill = skid_valid_q | evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign hold_refill = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      req_last_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], hs.req_t};
      req_last_q <= req_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (evt) state_d = HOLD;
      default: if (hs.out_ready && !hold_refill) state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    err_d       = err_q & ~err_clr;
`ifdef TGL_HS_RESP_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (evt) begin
          out_valid_d = 1'b1;
          out_data_d  = hs.din;
        end
      end
      default: begin
        if (hs.out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~ack_q;
          cnt_d       = cnt_q + CNT_W'(1);
        end
`ifdef TGL_HS_RESP_SKID_EN
        if (hs.out_ready && skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          skid_valid_d = evt;
          if (evt) skid_data_d = hs.din;
        end else if (hs.out_ready && evt) begin
          out_valid_d = 1'b1;
          out_data_d  = hs.din;
        end else if (evt && !skid_valid_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = hs.din;
        end else if (evt) begin
          err_d = 1'b1;
        end
`else
        if (evt) err_d = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign hs.out_valid = out_valid_q;
  assign hs.out_data  = out_data_q;
  assign hs.ack_t     = ack_q;
  assign evt_cnt      = cnt_q;
  assign err          = err_q;

endmodule
`default_nettype wire
